// File: rtl/datapath_mc.sv
// datapath_mc: multi-cycle RV32I datapath. The instruction and data memories are
// reached through req/ack handshakes. Decode stays in an external controller, which
// reads opcode/func3/func7 from the latched IR.
//
// state  | meaning
// FETCH  | instr_req high, wait for instr_valid, latch IR and PC+4
// DECODE | read rs1/rs2 into A/B, form PC+imm
// EXEC   | ALU into ALUOut; branches resolve and retire here
// MEM    | dmem_req high until dmem_ack; a load latches MDR, a store retires
// WB     | register-file write, PC update, retire
//
// ALUctl: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL,
//         0110 SUB, 0111 SLT, 1000 SLTU, 1001 SRA
module datapath_mc #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              instr_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              MemtoReg,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              lui,
  input  logic              U_type,
  input  logic              jal,
  input  logic              jalr,
  input  logic              beq,
  input  logic              bne,
  input  logic              blt,
  input  logic              bge,
  input  logic              bltu,
  input  logic              bgeu,
  input  logic [3:0]        ALUctl,
  output logic [6:0]        opcode,
  output logic [2:0]        func3,
  output logic              func7,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       ALU_result,
  output logic [31:0]       Wr_mem_data,
  input  logic [31:0]       Rd_mem_data,
  input  logic              dmem_ack,
  output logic [31:0]       pc_out,
  output logic              retire
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc, ir, a_q, b_q, alu_out, mdr, pc4, pci;
  logic [31:0] rf [0:31];
  logic [31:0] imm, alu_b, alu_y, rs1_val, rs2_val, wb_data;
  logic [4:0]  rs1, rs2, rd;
  logic        zero, lt, is_branch, taken;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  assign opcode = ir[6:0];
  assign func3  = ir[14:12];
  assign func7  = ir[30];

  // Requests are held off while reset is asserted, even though the state already reads FETCH.
  assign instr_req   = rst_n && (state == FETCH);
  assign dmem_req    = rst_n && (state == MEM);
  assign dmem_we     = dmem_req && MemWrite;
  assign rom_addr    = pc[ADDR_W+1:2];
  assign pc_out      = pc;
  assign ALU_result  = alu_out;
  assign Wr_mem_data = b_q;

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // Immediate extraction by instruction format, keyed on the IR opcode.
  always_comb begin
    imm = {{20{ir[31]}}, ir[31:20]};
    case (ir[6:0])
      7'b0100011:             imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011:             imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b0110111, 7'b0010111: imm = {ir[31:12], 12'd0};
      7'b1101111:             imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:                ;
    endcase
  end

  // ALU on the A register and either the immediate or the B register.
  always_comb begin
    alu_b = ALUSrc ? imm : b_q;
    alu_y = 32'd0;
    case (ALUctl)
      4'b0000: alu_y = a_q & alu_b;
      4'b0001: alu_y = a_q | alu_b;
      4'b0010: alu_y = a_q + alu_b;
      4'b0011: alu_y = a_q ^ alu_b;
      4'b0100: alu_y = a_q << alu_b[4:0];
      4'b0101: alu_y = a_q >> alu_b[4:0];
      4'b0110: alu_y = a_q - alu_b;
      4'b0111: alu_y = {31'd0, $signed(a_q) < $signed(alu_b)};
      4'b1000: alu_y = {31'd0, a_q < alu_b};
      4'b1001: alu_y = $signed(a_q) >>> alu_b[4:0];
      default: alu_y = 32'd0;
    endcase
  end

  // Branch resolution: SUB drives zero for beq/bne, SLT/SLTU bit 0 drives lt.
  assign zero      = (alu_y == 32'd0);
  assign lt        = alu_y[0];
  assign is_branch = beq | bne | blt | bge | bltu | bgeu;
  assign taken     = (beq & zero) | (bne & ~zero) | ((blt | bltu) & lt) | ((bge | bgeu) & ~lt);

  // Write-back source selection.
  always_comb begin
    wb_data = alu_out;
    if (U_type)            wb_data = lui ? imm : pci;
    else if (jal | jalr)   wb_data = pc4;
    else if (MemtoReg)     wb_data = mdr;
  end

  // Sequencer and architectural/pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
      pc4     <= 32'd0;
      pci     <= 32'd0;
      retire  <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            ir    <= instr;
            pc4   <= pc + 32'd4;
            state <= DECODE;
          end
        end
        DECODE: begin
          a_q   <= rs1_val;
          b_q   <= rs2_val;
          pci   <= pc + imm;
          state <= EXEC;
        end
        EXEC: begin
          alu_out <= alu_y;
          if (is_branch) begin
            pc     <= taken ? pci : pc4;
            retire <= 1'b1;
            state  <= FETCH;
          end else if (MemRead | MemWrite) begin
            state <= MEM;
          end else begin
            state <= WB;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            if (MemWrite) begin
              pc     <= pc4;
              retire <= 1'b1;
              state  <= FETCH;
            end else begin
              mdr   <= Rd_mem_data;
              state <= WB;
            end
          end
        end
        WB: begin
          pc     <= jalr ? {alu_out[31:1], 1'b0} : (jal ? pci : pc4);
          retire <= 1'b1;
          state  <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Register file: written only in WB, x0 never written, contents survive reset.
  always_ff @(posedge clk) begin
    if (rst_n && (state == WB) && RegWrite && (rd != 5'd0))
      rf[rd] <= wb_data;
  end

endmodule
